// File: rtl/io_cfg_pkg.sv
// Shared types and default geometry for the I/O tile configuration sequencer.
package io_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } io_cfg_state_e;

  localparam int IO_BL_WIDTH  = 3;
  localparam int IO_WL_WIDTH  = 3;
  localparam int IO_NUM_CELLS = 8;

endpackage

// File: rtl/io_cfg_row_packer.sv
// Serial-to-row assembly: collects configuration bits into one bit-line row.
module io_cfg_row_packer #(
  parameter int BL_WIDTH = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic                bit_i,
  output logic [0:BL_WIDTH-1] row_d_o,
  output logic                full_o
);
  localparam int CCW = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1;

  logic [CCW-1:0]      col_cnt_q;
  logic [0:BL_WIDTH-1] row_buf_q, row_buf_d;

  always_comb begin
    row_buf_d = row_buf_q;
    if (push_i) row_buf_d[col_cnt_q] = bit_i;
  end

  assign full_o  = push_i && (col_cnt_q == CCW'(BL_WIDTH-1));
  // The row including the bit being pushed, so the top can latch it on the same edge.
  assign row_d_o = row_buf_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      col_cnt_q <= '0;
      row_buf_q <= '0;
    end else if (push_i) begin
      row_buf_q <= row_buf_d;
      if (!full_o) col_cnt_q <= col_cnt_q + CCW'(1);
    end
  end

endmodule

// File: rtl/io_bank_config_ctrl.sv
// Programming sequencer: packs a serial bitstream into rows and pulses one word line per row.
module io_bank_config_ctrl
  import io_cfg_pkg::*;
#(
  parameter int BL_WIDTH  = IO_BL_WIDTH,
  parameter int WL_WIDTH  = IO_WL_WIDTH,
  parameter int NUM_CELLS = IO_NUM_CELLS,
  parameter int WL_PULSE  = 2
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic                busy,
  output logic                done
);
  localparam int RCW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int BCW = $clog2(NUM_CELLS + 1);
  localparam int PCW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  if (NUM_CELLS > BL_WIDTH*WL_WIDTH || NUM_CELLS == 0 || WL_PULSE == 0) begin : g_bad_param
    $fatal(1, "io_bank_config_ctrl: illegal NUM_CELLS/WL_PULSE for bank geometry");
  end

  io_cfg_state_e       state_q;
  logic [RCW-1:0]      row_cnt_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [PCW-1:0]      pulse_cnt_q;
  logic                cfg_ready_q, busy_q, done_q;
  logic [0:BL_WIDTH-1] bl_q, row_d;
  logic [0:WL_WIDTH-1] wl_q, wl_hot;
  logic                accept, row_full, row_end, pk_clr;

  assign accept  = cfg_ready_q && cfg_valid;
  assign row_end = accept && (row_full || bit_cnt_q == BCW'(NUM_CELLS-1));
  assign pk_clr  = ((state_q == ST_IDLE || state_q == ST_DONE) && start) || state_q == ST_HOLD;

  io_cfg_row_packer #(.BL_WIDTH(BL_WIDTH)) u_packer (
    .clk_i  (prog_clk),
    .rst_i  (pReset),
    .clr_i  (pk_clr),
    .push_i (accept),
    .bit_i  (cfg_bit),
    .row_d_o(row_d),
    .full_o (row_full)
  );

  always_comb begin
    wl_hot = '0;
    for (int i = 0; i < WL_WIDTH; i++) wl_hot[i] = (row_cnt_q == RCW'(i));
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      cfg_ready_q <= 1'b0;
      bl_q        <= '0;
      wl_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) begin
          state_q     <= ST_LOAD;
          row_cnt_q   <= '0;
          bit_cnt_q   <= '0;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b1;
          done_q      <= 1'b0;
        end
        ST_LOAD: if (accept) begin
          bit_cnt_q <= bit_cnt_q + BCW'(1);
          if (row_end) begin
            state_q     <= ST_SETUP;
            cfg_ready_q <= 1'b0;
            bl_q        <= row_d;
          end
        end
        ST_SETUP: begin
          state_q     <= ST_WRITE;
          pulse_cnt_q <= '0;
          wl_q        <= wl_hot;
        end
        ST_WRITE: begin
          if (pulse_cnt_q == PCW'(WL_PULSE-1)) begin
            state_q <= ST_HOLD;
            wl_q    <= '0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PCW'(1);
          end
        end
        ST_HOLD: begin
          bl_q <= '0;
          if (bit_cnt_q < BCW'(NUM_CELLS)) begin
            state_q     <= ST_LOAD;
            row_cnt_q   <= row_cnt_q + RCW'(1);
            cfg_ready_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
